// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared FSM state encoding and width helpers for the sweep checker
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction
endpackage

// File: rtl/tt_sweep_checker_if.sv
// tt_sweep_checker_if: vector offer / response channel between checker and evaluator
interface tt_sweep_checker_if #(parameter int N_IN = 3);
    logic            vec_valid;
    logic            vec_ready;
    logic [N_IN-1:0] vec;
    logic            vec_exp;
    logic            resp_valid;
    logic            resp_bit;
    modport master(output vec_valid, vec, vec_exp, input vec_ready, resp_valid, resp_bit);
    modport slave(input vec_valid, vec, vec_exp, output vec_ready, resp_valid, resp_bit);
endinterface

// File: rtl/tt_lut_mux.sv
// tt_lut_mux: selects the expected output bit for the current input vector
module tt_lut_mux
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [tt_width(N_IN)-1:0] tt,
    input  logic [N_IN-1:0]           idx,
    output logic                      bit_out
);
    assign bit_out = tt[idx];
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: walks every input vector of a truth table and scores evaluator responses
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 3,
    localparam int TT_W = tt_width(N_IN),
    localparam int CNT_W = cnt_width(N_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tt_load,
    input  logic [TT_W-1:0]     tt_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic                first_err_vld,
    output logic [N_IN-1:0]     first_err_idx,
    tt_sweep_checker_if.master  ev
);
    state_t          state, state_nx;
    logic [TT_W-1:0] tt;
    logic [N_IN-1:0] idx;
    logic            exp_bit, last, mis;

    tt_lut_mux #(.N_IN(N_IN)) u_lut (.tt(tt), .idx(idx), .bit_out(exp_bit));

    assign last         = &idx;
    assign mis          = ev.resp_bit != exp_bit;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign ev.vec_valid = state == ISSUE;
    assign ev.vec       = idx;
    assign ev.vec_exp   = exp_bit;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE      ? (start ? ISSUE : IDLE) :
                   state == ISSUE     ? (ev.vec_ready ? WAIT_RESP : ISSUE) :
                   state == WAIT_RESP ? (ev.resp_valid ? (last ? DONE : ISSUE) : WAIT_RESP) :
                   IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // table only writable in IDLE, so it is frozen for the whole sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt            <= '0;
            idx           <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (state == IDLE) begin
            if (tt_load) tt <= tt_data;
            if (start) begin
                idx           <= '0;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
            end
        end else if (state == WAIT_RESP && ev.resp_valid) begin
            idx <= idx + 1'b1;
            if (mis) err_count <= err_count + CNT_W'(1);
            if (mis && !first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= idx;
            end
            if (last) pass <= err_count == '0 && !mis;
        end
    end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: directed and randomized sweeps scored against a bench-side model
module tb_tt_sweep_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tt_load = 1'b0, start = 1'b0;
    logic [7:0]  tt_data = '0;
    logic        busy, done, pass, first_err_vld;
    logic [3:0]  err_count;
    logic [2:0]  first_err_idx;
    logic        tt_load4 = 1'b0, start4 = 1'b0;
    logic [15:0] tt_data4 = '0;
    logic        busy4, done4, pass4, first_err_vld4;
    logic [4:0]  err_count4;
    logic [3:0]  first_err_idx4;
    int          checks = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;

    tt_sweep_checker_if #(.N_IN(3)) ev3 ();
    tt_sweep_checker_if #(.N_IN(4)) ev4 ();

    tt_sweep_checker #(.N_IN(3)) d3 (
        .clk(clk), .rst(rst), .tt_load(tt_load), .tt_data(tt_data), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx), .ev(ev3.master)
    );
    tt_sweep_checker #(.N_IN(4)) d4 (
        .clk(clk), .rst(rst), .tt_load(tt_load4), .tt_data(tt_data4), .start(start4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
        .first_err_vld(first_err_vld4), .first_err_idx(first_err_idx4), .ev(ev4.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_vec_valid"}, ev3.vec_valid, 0);
        chk({tag, "_vec"}, ev3.vec, 0);
        chk({tag, "_vec_exp"}, ev3.vec_exp, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_vld"}, first_err_vld, 0);
        chk({tag, "_first_idx"}, first_err_idx, 0);
    endtask

    // Evaluator model: answers t[e]^flip[e]; stray wrong-bit responses outside WAIT_RESP must be ignored
    task automatic sweep(input logic [7:0] t, input logic [7:0] flip, input int max_stall,
                         input bit disturb, input int abort);
        int nerr = 0, first = -1;
        for (int i = 0; i < 8; i++) if (flip[i]) begin
            nerr++;
            if (first < 0) first = i;
        end
        tt_data = t; tt_load = 1'b1; start = 1'b1;
        @(negedge clk);
        cyc = 1; tt_load = 1'b0; start = 1'b0;
        for (int e = 0; e < 8; e++) begin
            int rs = int'($urandom_range(max_stall, 0));
            int ws = int'($urandom_range(max_stall, 0));
            ev3.resp_valid = 1'b1; ev3.resp_bit = ~t[e];
            for (int s = 0; s <= rs; s++) begin
                chk("vec_valid", ev3.vec_valid, 1);
                chk("vec", ev3.vec, e);
                chk("vec_exp", ev3.vec_exp, t[e]);
                chk("done_early", done, 0);
                ev3.vec_ready = (s == rs);
                if (disturb && e == 3 && s == rs) begin
                    tt_load = 1'b1; tt_data = 8'h00; start = 1'b1;
                end
                tick;
                tt_load = 1'b0; start = 1'b0;
            end
            ev3.vec_ready = 1'b0; ev3.resp_valid = 1'b0;
            for (int s = 0; s <= ws; s++) begin
                chk("outstanding", ev3.vec_valid, 0);
                chk("busy", busy, 1);
                if (e == abort) begin
                    rst = 1'b1;
                    #1;
                    chk_zero("async_rst");
                    repeat (3) begin
                        tick;
                        chk("rst_no_done", done, 0);
                    end
                    rst = 1'b0;
                    tick;
                    chk_zero("after_rst");
                    return;
                end
                ev3.resp_valid = (s == ws);
                ev3.resp_bit = t[e] ^ flip[e];
                tick;
            end
            ev3.resp_valid = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("pass", pass, nerr == 0);
        chk("err_count", err_count, nerr);
        chk("first_vld", first_err_vld, nerr > 0);
        chk("first_idx", first_err_idx, first < 0 ? 0 : first);
        tick;
        chk("done_single", done, 0);
        chk("busy_fall", busy, 0);
        chk("pass_hold", pass, nerr == 0);
        chk("err_hold", err_count, nerr);
    endtask

    initial begin
        ev3.vec_ready = 1'b0; ev3.resp_valid = 1'b0; ev3.resp_bit = 1'b0;
        ev4.vec_ready = 1'b0; ev4.resp_valid = 1'b0; ev4.resp_bit = 1'b0;
        repeat (2) tick;
        chk_zero("reset");
        rst = 1'b0;
        tick;
        sweep(8'hB9, 8'h00, 0, 1'b0, -1);
        sweep(8'hB9, 8'h60, 0, 1'b0, -1);
        sweep(8'h96, 8'h00, 5, 1'b0, -1);
        sweep(8'hB9, 8'h02, 0, 1'b0, 4);
        sweep(8'hB9, 8'h00, 0, 1'b0, -1);
        sweep(8'hB9, 8'h00, 2, 1'b1, -1);
        tt_data4 = 16'hB9B9; tt_load4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        cyc = 1; tt_load4 = 1'b0; start4 = 1'b0;
        for (int e = 0; e < 16; e++) begin
            chk("n4_vec_valid", ev4.vec_valid, 1);
            chk("n4_vec", ev4.vec, e);
            chk("n4_done_early", done4, 0);
            ev4.vec_ready = 1'b1;
            tick;
            ev4.vec_ready = 1'b0; ev4.resp_valid = 1'b1; ev4.resp_bit = tt_data4[e];
            tick;
            ev4.resp_valid = 1'b0;
        end
        chk("n4_done", done4, 1);
        chk("n4_pass", pass4, 1);
        chk("n4_err", err_count4, 0);
        tick;
        chk("n4_busy_fall", busy4, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Parametrised truth-table sweep checker for N-input genetic logic designs. It holds a programmable 2^N-bit truth table (e.g. 0xB9 for a 3-input design) and steps through every input combination. For each combination it issues a vector over a valid/ready handshake, then compares the returned output bit against the expected bit. It sits between the truth-table source and a circuit evaluator/simulator model, and reports a pass/fail verdict, a mismatch count and the first failing index.

## Interface
Parameters:
- N_IN, default 3: number of circuit inputs; 1..8.
- TT_W, derived, 2**N_IN: truth-table width (localparam, not overridable).
- CNT_W, derived, N_IN+1: width of the error counter; holds 0..2**N_IN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tt_load  in  1  capture tt_data into the table register (IDLE only).
- tt_data  in  TT_W  truth table; bit i = expected output for input vector i.
- start  in  1  begin a sweep (IDLE only).
- busy  out  1  high in every state except IDLE.
- vec_valid  out  1  vector offered.
- vec_ready  in  1  evaluator accepts vector.
- vec  out  N_IN  input combination; bit 0 = first input.
- vec_exp  out  1  tt[vec], for monitoring.
- resp_valid  in  1  evaluator response valid.
- resp_bit  in  1  observed circuit output.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last sweep had zero mismatches.
- err_count  out  CNT_W  mismatches in last/current sweep.
- first_err_vld  out  1  at least one mismatch recorded.
- first_err_idx  out  N_IN  index of first mismatch.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- **IDLE**
  - tt_load=1 registers tt_data.
  - start=1 clears err_count, first_err_vld, first_err_idx and pass; sets idx=0; moves to ISSUE.
  - If tt_load and start are both high in the same cycle: the new table is loaded and the sweep uses it.
- **ISSUE**
  - vec_valid=1, vec=idx, vec_exp=tt[idx]. vec and vec_exp stay stable while vec_ready=0.
  - On vec_valid&&vec_ready, move to WAIT_RESP.
- **WAIT_RESP**
  - vec_valid=0. On resp_valid:
    - If resp_bit!=tt[idx]: err_count+1. If first_err_vld=0, latch first_err_idx=idx and set first_err_vld=1.
    - If idx==TT_W-1, go to DONE; otherwise idx+1 and go to ISSUE.
- **DONE**
  - done=1 for one cycle. pass=(err_count==0) is registered and held.
  - Return to IDLE.
- Exactly one vector is outstanding at a time.
- resp_valid outside WAIT_RESP is ignored.
- resp_valid in the same cycle as the vector handshake is ignored.
- start or tt_load while busy are ignored. The table never changes mid-sweep.
- err_count cannot overflow (max TT_W fits CNT_W). No saturation logic.
- pass, err_count and first_err_* hold until the next accepted start.
- **Reset (asynchronous, any state, including mid-sweep):**
  - State=IDLE, tt=0, idx=0.
  - All outputs 0: busy, vec_valid, vec, vec_exp, done, pass, err_count, first_err_vld, first_err_idx.
  - The sweep is abandoned with no done pulse.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- start is sampled at edge 0. vec_valid is high in cycle 1.
- Minimum of 2 cycles per vector (ISSUE + WAIT_RESP), reached with vec_ready=1 and resp_valid in the first WAIT_RESP cycle.
- done is high in cycle 2*TT_W+1 after start at the best case. For N_IN=3 this is cycle 17.
- Each vec_ready stall cycle or resp_valid delay cycle adds exactly one cycle.
- busy falls in the cycle after done.

## Structure
- Shared package tt_sweep_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RESP, DONE);
  - a width helper function for TT_W and CNT_W from N_IN.
- One sub-module, tt_lut_mux: combinational TT_W:1 lookup of tt[idx], parametrised by N_IN. Used for vec_exp and for the comparison.

## Test plan
- N_IN=3, tt=0xB9, model responder returns tt[vec] with 0-cycle ready and 0-cycle response delay -> done at cycle 17, pass=1, err_count=0, first_err_vld=0, vec sequence 0..7.
- tt=0xB9, responder inverts bit for vec=5 and vec=6 -> err_count=2, first_err_vld=1, first_err_idx=5, pass=0.
- Random vec_ready and resp_valid stalls of 0–5 cycles, tt=0x96 -> vec stable while stalled, one vector outstanding at a time, cycle count = 17 + total stalls, pass=1.
- Async rst asserted in WAIT_RESP of idx=4 -> all outputs 0 immediately, no done pulse. After a new tt_load(0xB9) and start, a clean sweep passes.
- tt_load=0x00 and start pulsed mid-sweep with tt=0xB9 -> both ignored, sweep completes against 0xB9, exactly one done pulse.
- N_IN=4, tt=0xB9B9, correct responder -> done at cycle 33, pass=1, vec sequence 0..15.
